// File: rtl/pipelined_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_mult_pkg
//  Purpose  : Shared sizing helpers for the pipelined array multiplier.
//             - rows_per_stage : partial-product rows summed by each stage
//             - product_width  : width of the full, untruncated product
//             - config_ok      : elaboration-time legality of WIDTH/STAGES
//             The per-stage register record (stage_t) depends on WIDTH, so
//             it is declared inside the parameterised top module.
//  Options  : PIPELINED_MULT_SIGNED_EN (consumed by the top module)
//  Revision : 1.0 - initial release
// ============================================================================
package pipelined_mult_pkg;

  function automatic int unsigned rows_per_stage(input int unsigned width,
                                                 input int unsigned stages);
    return width / stages;
  endfunction

  function automatic int unsigned product_width(input int unsigned width);
    return 2 * width;
  endfunction

  // STAGES must split the WIDTH multiplier bits into equal row groups.
  function automatic bit config_ok(input int unsigned width,
                                   input int unsigned stages);
    return (width >= 2) && (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage : pipelined_mult_pkg
`default_nettype wire

// File: rtl/mult_pp_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pp_stage
//  Purpose  : Combinational row accumulator for one multiplier pipeline stage.
//             Adds rows FIRST_ROW .. FIRST_ROW+ROWS-1 of the array to sum_in:
//               sum_out = sum_in + sum_j (A & {WIDTH{B[j]}}) << j
//             In signed mode A is sign-extended to the product width (the
//             row correction) and the row of B's sign bit is subtracted.
//  Ports    : sum_in    [2W] running partial sum from the previous stage
//             a, b      [W]  operand copies carried down the pipe
//             is_signed [1]  two's-complement mode for this operand pair
//             sum_out   [2W] running partial sum after this stage's rows
//  Revision : 1.0 - initial release
// ============================================================================
module mult_pp_stage
  import pipelined_mult_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ROWS      = 2,
  parameter int FIRST_ROW = 0
) (
  input  logic [2*WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic [2*WIDTH-1:0] sum_out
);

  localparam int PW = product_width(WIDTH);

  logic [PW-1:0] a_ext;
  // Only this stage's slice of b feeds the adders; the rest is carried on.
  logic          unused_b;

  assign unused_b = ^b;

  always_comb begin
    a_ext   = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    sum_out = sum_in;
    for (int r = 0; r < ROWS; r++) begin
      if (b[FIRST_ROW + r]) begin
        // B's sign bit carries weight -2^(WIDTH-1) in signed mode.
        if (is_signed && ((FIRST_ROW + r) == (WIDTH - 1))) begin
          sum_out = sum_out - (a_ext << (FIRST_ROW + r));
        end else begin
          sum_out = sum_out + (a_ext << (FIRST_ROW + r));
        end
      end
    end
  end

endmodule : mult_pp_stage
`default_nettype wire

// File: rtl/pipelined_array_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_array_multiplier
//  Purpose  : STAGES-deep pipelined array multiplier with valid/ready
//             handshake and full backpressure. Each stage sums WIDTH/STAGES
//             partial-product rows; the product comes from the last stage.
//  Ports    : clk, rst            clock, synchronous active-high reset
//             in_valid/in_ready   operand handshake (A, B)
//             A, B       [W]      multiplicand, multiplier
//             is_signed  [1]      two's-complement operands (optional)
//             out_valid/out_ready product handshake
//             product    [2W]     A*B
//  Options  : PIPELINED_MULT_SIGNED_EN - adds the is_signed input.
//  Revision : 1.0 - initial release
// ============================================================================
module pipelined_array_multiplier
  import pipelined_mult_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
`ifdef PIPELINED_MULT_SIGNED_EN
  input  logic               is_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int ROWS = rows_per_stage(WIDTH, STAGES);
  localparam int PW   = product_width(WIDTH);

  if (!config_ok(WIDTH, STAGES)) begin : g_cfg_error
    $error("pipelined_array_multiplier: WIDTH must be >= 2 and divisible by STAGES");
  end

  typedef struct packed {
    logic             valid;
    logic [PW-1:0]    sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
  } stage_t;

  logic   sgn_req;
  stage_t stage_r [STAGES];
  logic   adv     [STAGES];
  logic   unused_tail;

`ifdef PIPELINED_MULT_SIGNED_EN
  assign sgn_req = is_signed;
`else
  assign sgn_req = 1'b0;
`endif

  // A stage may load when it is empty or its contents move on this cycle.
  // Evaluated from the output back, so a full pipe stalls as one unit and
  // bubbles collapse while the consumer is stalled.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      adv[s] = 1'b0;
    end
    adv[STAGES-1] = !stage_r[STAGES-1].valid || out_ready;
    for (int s = STAGES - 2; s >= 0; s--) begin
      adv[s] = !stage_r[s].valid || adv[s+1];
    end
  end

  assign in_ready = adv[0];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    stage_t           q;
    logic             v_in;
    logic [PW-1:0]    sum_in;
    logic [PW-1:0]    sum_nxt;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             sgn_in;

    if (s == 0) begin : g_head
      assign v_in   = in_valid;
      assign sum_in = '0;
      assign a_in   = A;
      assign b_in   = B;
      assign sgn_in = sgn_req;
    end else begin : g_body
      assign v_in   = stage_r[s-1].valid;
      assign sum_in = stage_r[s-1].sum;
      assign a_in   = stage_r[s-1].a;
      assign b_in   = stage_r[s-1].b;
      assign sgn_in = stage_r[s-1].is_signed;
    end

    mult_pp_stage #(
      .WIDTH     (WIDTH),
      .ROWS      (ROWS),
      .FIRST_ROW (s * ROWS)
    ) u_pp (
      .sum_in    (sum_in),
      .a         (a_in),
      .b         (b_in),
      .is_signed (sgn_in),
      .sum_out   (sum_nxt)
    );

    // Payload only updates when real data arrives, so an emptied stage
    // keeps its last value instead of toggling on bubbles.
    always_ff @(posedge clk) begin
      if (rst) begin
        q <= '0;
      end else if (adv[s]) begin
        q.valid <= v_in;
        if (v_in) begin
          q.sum       <= sum_nxt;
          q.a         <= a_in;
          q.b         <= b_in;
          q.is_signed <= sgn_in;
        end
      end
    end

    assign stage_r[s] = q;
  end

  assign out_valid = stage_r[STAGES-1].valid;
  assign product   = stage_r[STAGES-1].sum;

  // The last stage's operand copies have no consumer.
  assign unused_tail = ^{stage_r[STAGES-1].a, stage_r[STAGES-1].b,
                         stage_r[STAGES-1].is_signed};

endmodule : pipelined_array_multiplier
`default_nettype wire

// File: tb/tb_pipelined_array_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_array_multiplier
//  Purpose  : Self-checking bench: a WIDTH=8/STAGES=4 instance driven from a
//             vector table, backpressure, random-bubble and mid-stream reset
//             sequences, plus a WIDTH=4/STAGES=2 instance for exact timing.
//  Options  : PIPELINED_MULT_SIGNED_EN - adds signed vectors to the table.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_array_multiplier;

  localparam int W  = 8;
  localparam int S  = 4;
  localparam int SW = 4;
  localparam int SS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic           rst       = 1'b1;
  logic           in_valid  = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a         = '0;
  logic [W-1:0]   b         = '0;
  logic           sgn       = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] product;

  // Small instance
  logic            s_in_valid  = 1'b0;
  logic            s_in_ready;
  logic [SW-1:0]   s_a         = '0;
  logic [SW-1:0]   s_b         = '0;
  logic            s_out_valid;
  logic            s_out_ready = 1'b1;
  logic [2*SW-1:0] s_product;

  pipelined_array_multiplier #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
`ifdef PIPELINED_MULT_SIGNED_EN
    .is_signed (sgn),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  pipelined_array_multiplier #(.WIDTH(SW), .STAGES(SS)) u_small (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .A         (s_a),
    .B         (s_b),
`ifdef PIPELINED_MULT_SIGNED_EN
    .is_signed (1'b0),
`endif
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .product   (s_product)
  );

  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    logic           vs;
    logic [2*W-1:0] exp;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] exp;
    int             t;
  } sb_t;

  int             n_checks = 0;
  int             n_pass   = 0;
  int             ncyc     = 0;
  bit             chk_lat  = 1'b0;
  logic [2*W-1:0] drv_exp  = '0;
  sb_t            sb[$];
  vec_t           tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Scoreboard: every accepted operand pair must come out once, in order.
  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL spurious_output: product %0d delivered, expected no pending result", product);
          end else begin
            e = sb.pop_front();
            chk("product", product, e.exp);
            if (chk_lat) chk("latency", ncyc - e.t, S);
          end
        end
        if (in_valid && in_ready) sb.push_back('{drv_exp, ncyc});
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the transfer.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                      input logic ts, input logic [2*W-1:0] te);
    int n;
    a = ta; b = tb2; sgn = ts; drv_exp = te; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (S + 4) @(negedge clk);
    chk(name, sb.size(), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int acc;
    int k;
    int n_acc;
    int cyc;
    bit took;
    bit holding;
    logic [2*W-1:0] held;

    tbl.push_back('{8'd255, 8'd255, 1'b0, 16'd65025});
    tbl.push_back('{8'd0,   8'd255, 1'b0, 16'd0});
    tbl.push_back('{8'd128, 8'd2,   1'b0, 16'd256});
    tbl.push_back('{8'd1,   8'd1,   1'b0, 16'd1});
    tbl.push_back('{8'd200, 8'd100, 1'b0, 16'd20000});
    tbl.push_back('{8'd17,  8'd15,  1'b0, 16'd255});
    tbl.push_back('{8'd255, 8'd1,   1'b0, 16'd255});
    tbl.push_back('{8'd2,   8'd128, 1'b0, 16'd256});
    tbl.push_back('{8'd170, 8'd85,  1'b0, 16'd14450});
    tbl.push_back('{8'd0,   8'd0,   1'b0, 16'd0});
`ifdef PIPELINED_MULT_SIGNED_EN
    tbl.push_back('{8'hFD,  8'd5,   1'b1, 16'hFFF1});
    tbl.push_back('{8'h80,  8'h80,  1'b1, 16'd16384});
    tbl.push_back('{8'd253, 8'd5,   1'b0, 16'd1265});
    tbl.push_back('{8'hFF,  8'hFF,  1'b1, 16'd1});
    tbl.push_back('{8'h7F,  8'h80,  1'b1, 16'hC080});
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", product, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_s_out_valid", s_out_valid, 0);
    chk("rst_s_product", s_product, 0);

    // WIDTH=4, STAGES=2: three back-to-back pairs, 2-cycle latency
    @(posedge clk); #1;
    s_in_valid = 1'b1; s_a = 4'd1; s_b = 4'd0;
    @(negedge clk);
    chk("t1_empty_c0", s_out_valid, 0);
    @(posedge clk); #1;
    s_a = 4'd10; s_b = 4'd3;
    @(negedge clk);
    chk("t1_empty_c1", s_out_valid, 0);
    chk("t1_in_ready", s_in_ready, 1);
    @(posedge clk); #1;
    s_a = 4'd13; s_b = 4'd10;
    @(negedge clk);
    chk("t1_valid0", s_out_valid, 1);
    chk("t1_prod0", s_product, 0);
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid1", s_out_valid, 1);
    chk("t1_prod1", s_product, 30);
    @(negedge clk);
    chk("t1_valid2", s_out_valid, 1);
    chk("t1_prod2", s_product, 130);
    @(negedge clk);
    chk("t1_idle", s_out_valid, 0);

    // Table vectors back-to-back, out_ready high, latency STAGES
    chk_lat = 1'b1;
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      a = tbl[i].va; b = tbl[i].vb; sgn = tbl[i].vs; drv_exp = tbl[i].exp;
      @(negedge clk);
      chk("t2_in_ready", in_ready, 1);
    end
    drain("t2_drained");
    chk_lat = 1'b0;

    // Backpressure: continuous stream with a stalled consumer
    @(posedge clk); #1;
    out_ready = 1'b0;
    k = 0; acc = 0;
    a = W'(k + 3); b = W'(2 * k + 7); drv_exp = (2*W)'((k + 3) * (2 * k + 7));
    sgn = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      took = in_valid && in_ready;
      if (took) acc++;
      @(posedge clk); #1;
      if (took) begin
        k++;
        a = W'(k + 3); b = W'(2 * k + 7); drv_exp = (2*W)'((k + 3) * (2 * k + 7));
      end
    end
    @(negedge clk);
    chk("t3_accepted", acc, 4);
    chk("t3_in_ready_low", in_ready, 0);
    chk("t3_out_valid", out_valid, 1);
    chk("t3_head", product, 21);
    held = product;
    repeat (2) begin
      @(negedge clk);
      chk("t3_hold", product, held);
      chk("t3_hold_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_in_ready_release", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int j = 5; j < 8; j++) send(W'(j + 3), W'(2 * j + 7), 1'b0, (2*W)'((j + 3) * (2 * j + 7)));
    drain("t3_drained");

    // Random bubbles on both sides
    n_acc = 0; cyc = 0; holding = 1'b0;
    while (n_acc < 1000 && cyc < 20000) begin
      @(posedge clk); #1;
      if (!holding) begin
        in_valid = ($urandom_range(0, 2) != 0);
        a = W'($urandom); b = W'($urandom); sgn = 1'b0;
        drv_exp = (2*W)'(a) * (2*W)'(b);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        n_acc++;
        holding = 1'b0;
      end else begin
        holding = in_valid;
      end
      cyc++;
    end
    chk("t4_count", n_acc, 1000);
    drain("t4_drained");

    // Reset with three results in flight and a handshake during reset
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(8'd11, 8'd12, 1'b0, 16'd132);
    send(8'd13, 8'd14, 1'b0, 16'd182);
    send(8'd15, 8'd16, 1'b0, 16'd240);
    a = 8'd9; b = 8'd9; drv_exp = 16'd81; in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_product", product, 0);
    chk("t5_in_ready", in_ready, 1);
    repeat (10) @(negedge clk);
    chk("t5_no_stale", sb.size(), 0);
    @(posedge clk); #1;
    send(8'd6, 8'd7, 1'b0, 16'd42);
    drain("t5_drained");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pipelined_array_multiplier
`default_nettype wire
